// File: rtl/gpio_banked.sv
// Banked GPIO: per-pin direction, atomic set/clear/toggle of the output register,
// input synchroniser and edge-triggered interrupts with write-1-to-clear status.
module gpio_banked #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             write_i,
  input  logic [3:0]       data_be_i,
  input  logic [5:0]       addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o,
  input  logic [WIDTH-1:0] input_i,
  output logic [WIDTH-1:0] output_o,
  output logic [WIDTH-1:0] oe_o,
  output logic             irq_o
);

  localparam logic [3:0] W_IDR  = 4'h0;
  localparam logic [3:0] W_ODR  = 4'h1;
  localparam logic [3:0] W_DIR  = 4'h2;
  localparam logic [3:0] W_OSET = 4'h3;
  localparam logic [3:0] W_OCLR = 4'h4;
  localparam logic [3:0] W_OTGL = 4'h5;
  localparam logic [3:0] W_IER  = 4'h6;
  localparam logic [3:0] W_RISE = 4'h7;
  localparam logic [3:0] W_FALL = 4'h8;
  localparam logic [3:0] W_ISR  = 4'h9;

  logic [3:0]       word;
  logic [31:0]      be_mask;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] wdm;
  logic [WIDTH-1:0] odr, dir, ier, rise_en, fall_en, isr;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] idr, idr_d;
  logic [WIDTH-1:0] evt, w1c;
  logic [WIDTH-1:0] rd_w;
  logic [31:0]      rd_full;
  logic             unused_bits;

  assign word    = addr_i[5:2];
  assign be_mask = {{8{data_be_i[3]}}, {8{data_be_i[2]}}, {8{data_be_i[1]}}, {8{data_be_i[0]}}};
  assign wmask   = be_mask[WIDTH-1:0];
  // Disabled lanes behave as all-zero data for the set/clear/toggle/W1C words.
  assign wdm     = wdata_i[WIDTH-1:0] & wmask;
  assign unused_bits = ^{addr_i[1:0], wdata_i, be_mask};

  assign idr = sync_q[SYNC_STAGES-1];
  assign evt = (idr & ~idr_d & rise_en) | (~idr & idr_d & fall_en);
  assign w1c = (write_i && word == W_ISR) ? wdm : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      idr_d <= '0;
    end else begin
      sync_q[0] <= input_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      idr_d <= idr;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      odr     <= '0;
      dir     <= '0;
      ier     <= '0;
      rise_en <= '0;
      fall_en <= '0;
    end else if (write_i) begin
      case (word)
        W_ODR:   odr     <= (odr & ~wmask) | wdm;
        W_OSET:  odr     <= odr | wdm;
        W_OCLR:  odr     <= odr & ~wdm;
        W_OTGL:  odr     <= odr ^ wdm;
        W_DIR:   dir     <= (dir & ~wmask) | wdm;
        W_IER:   ier     <= (ier & ~wmask) | wdm;
        W_RISE:  rise_en <= (rise_en & ~wmask) | wdm;
        W_FALL:  fall_en <= (fall_en & ~wmask) | wdm;
        default: ;
      endcase
    end
  end

  // A new event in the same cycle as a clear keeps the status bit set.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) isr <= '0;
    else       isr <= (isr & ~w1c) | evt;
  end

  always_comb begin
    rd_w = '0;
    case (word)
      W_IDR:   rd_w = idr;
      W_ODR:   rd_w = odr;
      W_DIR:   rd_w = dir;
      W_IER:   rd_w = ier;
      W_RISE:  rd_w = rise_en;
      W_FALL:  rd_w = fall_en;
      W_ISR:   rd_w = isr;
      default: rd_w = '0;
    endcase
    rd_full = '0;
    rd_full[WIDTH-1:0] = rd_w;
  end

  assign rdata_o  = rd_full & be_mask;
  assign output_o = odr;
  assign oe_o     = dir;
  assign irq_o    = |(isr & ier);

endmodule

// File: tb/tb_gpio_banked.sv
// Directed bench for gpio_banked: a 16-pin instance plus an 8-pin instance
// sharing the same bus, checked with immediate assertions.
module tb_gpio_banked;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        write_i;
  logic [3:0]  data_be_i;
  logic [5:0]  addr_i;
  logic [31:0] wdata_i;
  logic [15:0] input_i;
  logic [31:0] rdata16, rdata8;
  logic [15:0] out16, oe16;
  logic [7:0]  out8, oe8;
  logic        irq16, irq8;

  int total  = 0;
  int passed = 0;

  gpio_banked #(.WIDTH(16), .SYNC_STAGES(2)) u16 (
    .clk_i(clk_i), .rst_i(rst_i), .write_i(write_i), .data_be_i(data_be_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata16), .input_i(input_i),
    .output_o(out16), .oe_o(oe16), .irq_o(irq16)
  );

  gpio_banked #(.WIDTH(8), .SYNC_STAGES(2)) u8 (
    .clk_i(clk_i), .rst_i(rst_i), .write_i(write_i), .data_be_i(data_be_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata8), .input_i(input_i[7:0]),
    .output_o(out8), .oe_o(oe8), .irq_o(irq8)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk_i);
    write_i   = 1'b1;
    addr_i    = a;
    wdata_i   = d;
    data_be_i = be;
    @(negedge clk_i);
    write_i   = 1'b0;
  endtask

  task automatic peek(input logic [5:0] a, input logic [3:0] be);
    write_i   = 1'b0;
    addr_i    = a;
    data_be_i = be;
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  initial begin
    // reset while a write is on the bus and all pins are high
    rst_i     = 1'b1;
    write_i   = 1'b1;
    addr_i    = 6'h04;
    wdata_i   = 32'hFFFF_FFFF;
    data_be_i = 4'hF;
    input_i   = 16'hFFFF;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_out", {16'h0, out16}, 32'h0);
    check("rst_oe", {16'h0, oe16}, 32'h0);
    check("rst_irq", {31'h0, irq16}, 32'h0);
    check("rst_out8", {24'h0, out8}, 32'h0);
    peek(6'h24, 4'hF);
    check("rst_isr", rdata16, 32'h0);
    @(negedge clk_i);
    rst_i   = 1'b0;
    input_i = 16'h0000;
    wait_cycles(5);
    peek(6'h04, 4'hF);
    check("post_rst_odr", rdata16, 32'h0);

    // output register and atomic set/clear/toggle
    wr(6'h04, 32'h0000_00A5, 4'b0001);
    check("odr_wr", {16'h0, out16}, 32'h0000_00A5);
    wr(6'h0C, 32'h0000_0F00, 4'hF);
    check("oset", {16'h0, out16}, 32'h0000_0FA5);
    wr(6'h10, 32'h0000_0005, 4'hF);
    check("oclr", {16'h0, out16}, 32'h0000_0FA0);
    wr(6'h14, 32'h0000_8000, 4'hF);
    check("otgl", {16'h0, out16}, 32'h0000_8FA0);
    peek(6'h04, 4'hF);
    check("odr_rd", rdata16, 32'h0000_8FA0);
    peek(6'h0C, 4'hF);
    check("oset_rd0", rdata16, 32'h0);
    wr(6'h04, 32'h0000_FFFF, 4'b0010);
    check("odr_lane1", {16'h0, out16}, 32'h0000_FFA0);
    wr(6'h0C, 32'h0000_FFFF, 4'b0001);
    check("oset_lane0", {16'h0, out16}, 32'h0000_FFFF);
    wr(6'h08, 32'h0000_00FF, 4'b0001);
    check("dir_oe", {16'h0, oe16}, 32'h0000_00FF);
    check("out_keep", {16'h0, out16}, 32'h0000_FFFF);
    peek(6'h08, 4'hF);
    check("dir_rd", rdata16, 32'h0000_00FF);

    // rising edge on bit3: IDR after k+1, ISR/irq after k+2
    wr(6'h1C, 32'h0000_0008, 4'hF);
    wr(6'h18, 32'h0000_0008, 4'hF);
    input_i = 16'h0008;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    peek(6'h00, 4'hF);
    check("idr_lat", rdata16, 32'h0000_0008);
    check("irq_early", {31'h0, irq16}, 32'h0);
    @(posedge clk_i);
    #1;
    check("irq_rise", {31'h0, irq16}, 32'h1);
    peek(6'h24, 4'hF);
    check("isr_rise", rdata16, 32'h0000_0008);
    wr(6'h24, 32'h0000_0008, 4'hF);
    check("irq_w1c", {31'h0, irq16}, 32'h0);
    peek(6'h24, 4'hF);
    check("isr_w1c", rdata16, 32'h0);

    // falling edge on bit0 with IER masked, then unmasked
    input_i = 16'h0009;
    wait_cycles(4);
    wr(6'h20, 32'h0000_0001, 4'hF);
    input_i = 16'h0008;
    wait_cycles(4);
    peek(6'h24, 4'hF);
    check("isr_fall", rdata16, 32'h0000_0001);
    check("irq_masked", {31'h0, irq16}, 32'h0);
    wr(6'h18, 32'h0000_0009, 4'hF);
    check("irq_unmask", {31'h0, irq16}, 32'h1);
    wr(6'h24, 32'h0000_0001, 4'hF);
    check("irq_clr0", {31'h0, irq16}, 32'h0);

    // set-wins: W1C of ISR[5] at the same edge as a new rise on bit5
    wr(6'h1C, 32'h0000_0028, 4'hF);
    input_i = 16'h0028;
    wait_cycles(4);
    peek(6'h24, 4'hF);
    check("isr5_first", rdata16, 32'h0000_0020);
    input_i = 16'h0008;
    wait_cycles(4);
    input_i = 16'h0028;
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    write_i   = 1'b1;
    addr_i    = 6'h24;
    wdata_i   = 32'h0000_0020;
    data_be_i = 4'hF;
    @(negedge clk_i);
    write_i   = 1'b0;
    peek(6'h24, 4'hF);
    check("isr5_setwins", rdata16, 32'h0000_0020);
    wr(6'h24, 32'h0000_0020, 4'hF);
    peek(6'h24, 4'hF);
    check("isr5_clr", rdata16, 32'h0);

    // unmapped words, lane-masked reads and the 8-pin instance
    wr(6'h04, 32'h0000_1234, 4'hF);
    wr(6'h2C, 32'hFFFF_FFFF, 4'hF);
    check("unmapped_wr", {16'h0, out16}, 32'h0000_1234);
    peek(6'h2C, 4'hF);
    check("unmapped_rd", rdata16, 32'h0);
    peek(6'h04, 4'b0010);
    check("rd_lane1", rdata16, 32'h0000_1200);
    wr(6'h04, 32'hFFFF_FFFF, 4'hF);
    peek(6'h04, 4'hF);
    check("w8_odr_rd", rdata8, 32'h0000_00FF);
    check("w16_odr_rd", rdata16, 32'h0000_FFFF);
    check("w8_out", {24'h0, out8}, 32'h0000_00FF);
    peek(6'h2C, 4'hF);
    check("w8_unmapped", rdata8, 32'h0);
    peek(6'h04, 4'b0010);
    check("w8_lane1", rdata8, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
